ibex_fetch_queue: RTL

Parametrised instruction fetch queue, the next-generation replacement for the fixed-depth prefetch buffer inside the IF stage. It issues word-aligned requests on the instruction bus and tracks up to Depth outstanding/buffered words. It assembles 16/32-bit instructions, including 32-bit instructions straddling a word boundary, and presents one instruction per cycle with its PC. Branch flush discards in-flight responses without stalling the bus.

---
 rtl/ibex_fetch_queue.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/ibex_fetch_queue.sv
// Instruction fetch queue: word requests on the instruction bus, 16/32-bit assembly, branch flush.
// Optional same-cycle response bypass when IBEX_FETCH_QUEUE_BYPASS_EN is defined.
module ibex_fetch_queue #(
  parameter int unsigned Depth     = 3,
  parameter logic [31:0] ResetAddr = 32'h0000_0080
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       req_i,
  input  logic                       branch_i,
  input  logic [31:0]                branch_addr_i,
  output logic                       instr_req_o,
  output logic [31:0]                instr_addr_o,
  input  logic                       instr_gnt_i,
  input  logic                       instr_rvalid_i,
  input  logic [31:0]                instr_rdata_i,
  input  logic                       instr_err_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [31:0]                out_rdata_o,
  output logic [31:0]                out_addr_o,
  output logic                       out_err_o,
  output logic                       busy_o,
  output logic [$clog2(Depth+1)-1:0] count_o
);
  localparam int unsigned CW = $clog2(Depth + 1);
  localparam logic [CW:0] DepthW = Depth[CW:0];

  logic [31:0]   fifo_data_q [Depth];
  logic [31:0]   fifo_data_d [Depth];
  logic [Depth-1:0] fifo_err_q, fifo_err_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [31:0]   fetch_addr_q, fetch_addr_d;
  logic [31:0]   out_addr_q, out_addr_d;

  logic [CW:0]   occupancy;
  logic          req_gnt;
  logic          resp_drop;
  logic          resp_keep;
  logic          bypass;
  logic [31:0]   head_data;
  logic          head_err;
  logic [CW-1:0] words_avail;
  logic          offset;
  logic [15:0]   lo_half;
  logic          is_compressed;
  logic          straddle;
  logic          words_ok;
  logic [31:0]   instr;
  logic          instr_err;
  logic          out_valid;
  logic          consume;
  logic          pop;
  logic          fifo_pop;
  logic          push;
  logic [CW-1:0] wr_idx;

  // Requests are throttled so buffered plus in-flight words never exceed Depth.
  assign occupancy   = {1'b0, count_q} + {1'b0, outst_q};
  assign instr_req_o = req_i & (occupancy < DepthW);
  assign req_gnt     = instr_req_o & instr_gnt_i;
  assign resp_drop   = instr_rvalid_i & (discard_q != '0);
  assign resp_keep   = instr_rvalid_i & (discard_q == '0);

`ifdef IBEX_FETCH_QUEUE_BYPASS_EN
  assign bypass = resp_keep & (count_q == '0);
`else
  assign bypass = 1'b0;
`endif

  assign head_data   = bypass ? instr_rdata_i : fifo_data_q[0];
  assign head_err    = bypass ? instr_err_i   : fifo_err_q[0];
  assign words_avail = bypass ? CW'(1)        : count_q;

  always_comb begin
    offset        = out_addr_q[1];
    lo_half       = offset ? head_data[31:16] : head_data[15:0];
    is_compressed = (lo_half[1:0] != 2'b11);
    straddle      = offset & ~is_compressed;
    if (is_compressed) begin
      instr = {16'h0000, lo_half};
    end else if (straddle) begin
      instr = {fifo_data_q[1][15:0], lo_half};
    end else begin
      instr = head_data;
    end
    instr_err = head_err | (straddle & fifo_err_q[1]);
    // A straddling instruction can never come from the bypass path: it needs two buffered words.
    words_ok  = straddle ? (count_q >= CW'(2)) : (words_avail != '0);
  end

  assign out_valid = words_ok & ~branch_i;
  assign consume   = out_valid & out_ready_i;
  assign pop       = consume & (offset | ~is_compressed);
  assign fifo_pop  = pop & ~bypass;
  // A bypassed word that is fully consumed this cycle is never stored.
  assign push      = resp_keep & ~(bypass & pop);
  assign wr_idx    = count_q - CW'(fifo_pop);

  always_comb begin
    fifo_data_d = fifo_data_q;
    fifo_err_d  = fifo_err_q;
    if (fifo_pop) begin
      for (int i = 0; i < int'(Depth) - 1; i++) begin
        fifo_data_d[i] = fifo_data_q[i+1];
        fifo_err_d[i]  = fifo_err_q[i+1];
      end
    end
    if (push && ({1'b0, wr_idx} < DepthW)) begin
      fifo_data_d[wr_idx] = instr_rdata_i;
      fifo_err_d[wr_idx]  = instr_err_i;
    end
  end

  always_comb begin
    outst_d      = outst_q + CW'(req_gnt) - CW'(instr_rvalid_i);
    count_d      = count_q + CW'(push) - CW'(fifo_pop);
    discard_d    = discard_q - CW'(resp_drop);
    fetch_addr_d = fetch_addr_q;
    out_addr_d   = out_addr_q;
    if (req_gnt) begin
      fetch_addr_d = fetch_addr_q + 32'd4;
    end
    if (consume) begin
      out_addr_d = out_addr_q + (is_compressed ? 32'd2 : 32'd4);
    end
    // Every request still in flight after this edge, including one granted now, targets the old stream.
    if (branch_i) begin
      count_d      = '0;
      discard_d    = outst_d;
      out_addr_d   = branch_addr_i & ~32'h1;
      fetch_addr_d = branch_addr_i & ~32'h3;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q      <= '0;
      outst_q      <= '0;
      discard_q    <= '0;
      fetch_addr_q <= ResetAddr & ~32'h3;
      out_addr_q   <= ResetAddr;
    end else begin
      count_q      <= count_d;
      outst_q      <= outst_d;
      discard_q    <= discard_d;
      fetch_addr_q <= fetch_addr_d;
      out_addr_q   <= out_addr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    fifo_data_q <= fifo_data_d;
    fifo_err_q  <= fifo_err_d;
  end

  assign instr_addr_o = fetch_addr_q;
  assign out_valid_o  = out_valid;
  assign out_rdata_o  = out_valid ? instr : 32'h0;
  assign out_err_o    = out_valid & instr_err;
  assign out_addr_o   = out_addr_q;
  assign busy_o       = (outst_q != '0) | instr_req_o;
  assign count_o      = count_q;

`ifndef SYNTHESIS
  fifo_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push && !fifo_pop && !branch_i && ({1'b0, count_q} == DepthW)));
`endif

endmodule
